// File: rtl/mips_pkg.sv
// Shared types and constants for the mini-MIPS fetch/execute sequencer.
// Holds the sequencer state enum, PC step, default exception vector and alignment mask.
package mips_pkg;

   typedef enum logic [1:0] {
      ST_START = 2'd0,
      ST_FETCH = 2'd1,
      ST_EXEC  = 2'd2,
      ST_HALT  = 2'd3
   } seq_state_t;

   localparam logic [31:0] PC_STEP          = 32'd4;
   localparam logic [31:0] EXC_VECTOR_DFLT  = 32'h0000_0080;
   localparam logic [31:0] WORD_ALIGN_MASK  = 32'h0000_0003;

   function automatic logic is_misaligned(input logic [31:0] a);
      return (a & WORD_ALIGN_MASK) != 32'd0;
   endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Instruction-memory fetch port bundle.
// master: sequencer (req/addr out, rdata/valid in); slave: memory.
interface pc_sequencer_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        imem_valid;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_rdata,
      input  imem_valid
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_rdata,
      output imem_valid
   );
endinterface

// File: rtl/pc_target_mux.sv
// Redirect target select: halt > jump > branch > sequential, plus alignment check.
// Ports: i_pc/i_* redirect controls in; o_target final next PC, o_fault misaligned redirect.
module pc_target_mux
   import mips_pkg::*;
#(
   parameter logic [31:0] EXC_VECTOR = mips_pkg::EXC_VECTOR_DFLT,
   parameter logic [31:0] PC_STEP    = mips_pkg::PC_STEP
) (
   input  logic [31:0] i_pc,
   input  logic        i_halt,
   input  logic        i_jmp,
   input  logic [31:0] i_jmp_target,
   input  logic        i_br,
   input  logic [31:0] i_br_target,
   output logic [31:0] o_target,
   output logic        o_fault
);

   logic [31:0] w_sel;
   logic        w_redir;

   always_comb begin
      w_sel   = i_pc + PC_STEP;
      w_redir = 1'b0;
      if (i_halt) begin
         w_sel = i_pc;
      end else if (i_jmp) begin
         w_sel   = i_jmp_target;
         w_redir = 1'b1;
      end else if (i_br) begin
         w_sel   = i_br_target;
         w_redir = 1'b1;
      end
   end

   // Only jump/branch targets can fault; sequential wrap is legal.
   assign o_fault  = w_redir & is_misaligned(w_sel);
   assign o_target = o_fault ? EXC_VECTOR : w_sel;

endmodule

// File: rtl/pc_sequencer.sv
// Fetch/execute sequencer driving the PC register's next value and the imem port.
// Ports: clk/reset, pc in, next_pc out, bus (imem master), execute redirects, exception/halt status.
module pc_sequencer
   import mips_pkg::*;
#(
   parameter logic [31:0] EXC_VECTOR = mips_pkg::EXC_VECTOR_DFLT,
   parameter logic [31:0] PC_STEP    = mips_pkg::PC_STEP
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [31:0]           pc,
   output logic [31:0]           next_pc,
   pc_sequencer_if.master        bus,
   output logic [31:0]           instr,
   output logic                  instr_valid,
   input  logic                  ex_done,
   input  logic                  br_taken,
   input  logic [31:0]           br_target,
   input  logic                  jmp,
   input  logic [31:0]           jmp_target,
   input  logic                  halt_req,
   input  logic                  exc_ack,
   output logic                  exc_flag,
   output logic [31:0]           epc,
   output logic                  halted
);

   seq_state_t  r_state;
   seq_state_t  w_state_nxt;
   logic [31:0] r_instr;
   logic        r_exc;
   logic [31:0] r_epc;
   logic        w_req;
   logic        w_ivalid;
   logic        w_halted;
   logic        w_redirect;
   logic [31:0] w_target;
   logic        w_fault;

   pc_target_mux #(
      .EXC_VECTOR (EXC_VECTOR),
      .PC_STEP    (PC_STEP)
   ) u_mux (
      .i_pc         (pc),
      .i_halt       (halt_req),
      .i_jmp        (jmp),
      .i_jmp_target (jmp_target),
      .i_br         (br_taken),
      .i_br_target  (br_target),
      .o_target     (w_target),
      .o_fault      (w_fault)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_req       = 1'b0;
      w_ivalid    = 1'b0;
      w_halted    = 1'b0;
      unique case (r_state)
         ST_START: w_state_nxt = ST_FETCH;
         ST_FETCH: begin
            w_req = 1'b1;
            if (bus.imem_valid) w_state_nxt = ST_EXEC;
         end
         ST_EXEC: begin
            w_ivalid = 1'b1;
            if (ex_done)
               w_state_nxt = halt_req ? ST_HALT : ST_FETCH;
         end
         ST_HALT: w_halted = 1'b1;
         default: w_state_nxt = ST_START;
      endcase
   end

   // The PC register loads every clock, so holding means feeding pc back.
   assign w_redirect = (r_state == ST_EXEC) && ex_done;
   assign next_pc    = w_redirect ? w_target : pc;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_START;
         r_instr <= '0;
         r_exc   <= 1'b0;
         r_epc   <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == ST_FETCH && bus.imem_valid)
            r_instr <= bus.imem_rdata;
         // A new fault beats a same-cycle acknowledge.
         if (w_redirect && w_fault) begin
            r_exc <= 1'b1;
            r_epc <= pc;
         end else if (exc_ack) begin
            r_exc <= 1'b0;
         end
      end
   end

   assign bus.imem_req  = w_req;
   assign bus.imem_addr = pc;
   assign instr         = r_instr;
   assign instr_valid   = w_ivalid;
   assign exc_flag      = r_exc;
   assign epc           = r_epc;
   assign halted        = w_halted;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed program walk plus random
// fetch/execute traffic against a transaction-level PC model.
module tb_pc_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] pc;
   logic [31:0] next_pc;
   logic [31:0] instr;
   logic        instr_valid;
   logic        ex_done, br_taken, jmp, halt_req, exc_ack;
   logic [31:0] br_target, jmp_target;
   logic        exc_flag;
   logic [31:0] epc;
   logic        halted;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   int last_acc = 0;

   logic [31:0] m_pc, m_epc, m_instr;
   logic        m_exc;

   localparam logic [31:0] EXC_VEC = 32'h0000_0080;

   pc_sequencer_if bus();

   pc_sequencer #(
      .EXC_VECTOR (EXC_VEC),
      .PC_STEP    (32'd4)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .pc          (pc),
      .next_pc     (next_pc),
      .bus         (bus.master),
      .instr       (instr),
      .instr_valid (instr_valid),
      .ex_done     (ex_done),
      .br_taken    (br_taken),
      .br_target   (br_target),
      .jmp         (jmp),
      .jmp_target  (jmp_target),
      .halt_req    (halt_req),
      .exc_ack     (exc_ack),
      .exc_flag    (exc_flag),
      .epc         (epc),
      .halted      (halted)
   );

   always #5 clk = ~clk;

   // PC register: loads next_pc unconditionally.
   always @(posedge clk or posedge reset)
      if (reset) pc <= 32'd0;
      else       pc <= next_pc;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #400000;
      $display("FAIL global_timeout: observed no finish expected finish");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic clear_ctl();
      ex_done = 0; br_taken = 0; jmp = 0; halt_req = 0; exc_ack = 0;
      br_target = 0; jmp_target = 0;
   endtask

   task automatic noise();
      ex_done    = 1'($urandom_range(0, 1));
      br_taken   = 1'($urandom_range(0, 1));
      jmp        = 1'($urandom_range(0, 1));
      halt_req   = 1'($urandom_range(0, 1));
      br_target  = $urandom;
      jmp_target = $urandom;
   endtask

   task automatic do_reset();
      reset = 1;
      bus.imem_valid = 0;
      bus.imem_rdata = 0;
      clear_ctl();
      #1;
      chk("rst_req", bus.imem_req, 0);
      chk("rst_instr", instr, 0);
      chk("rst_ivalid", instr_valid, 0);
      chk("rst_exc", exc_flag, 0);
      chk("rst_epc", epc, 0);
      chk("rst_halted", halted, 0);
      chk("rst_npc", next_pc, 0);
      @(posedge clk); #1;
      reset = 0;
      m_pc = 0; m_exc = 0; m_epc = 0; m_instr = 0;
      chk("start_req", bus.imem_req, 0);
      @(posedge clk); #1;
      chk("first_req", bus.imem_req, 1);
   endtask

   task automatic fetch(input int stall, input logic [31:0] data,
                        input bit gap_chk);
      int k = 0;
      while (bus.imem_req !== 1'b1 && k < 8) begin
         @(posedge clk); #1; k++;
      end
      chk("req", bus.imem_req, 1);
      chk("addr", bus.imem_addr, m_pc);
      for (int i = 0; i < stall; i++) begin
         bus.imem_valid = 0;
         bus.imem_rdata = $urandom;
         noise();
         @(negedge clk);
         chk("stall_npc", next_pc, m_pc);
         @(posedge clk); #1;
         chk("stall_pc", pc, m_pc);
         chk("stall_req", bus.imem_req, 1);
         chk("stall_addr", bus.imem_addr, m_pc);
      end
      clear_ctl();
      bus.imem_valid = 1;
      bus.imem_rdata = data;
      @(negedge clk);
      chk("fetch_npc", next_pc, m_pc);
      @(posedge clk); #1;
      bus.imem_valid = 0;
      if (gap_chk) chk("gap", cyc - last_acc, 2);
      last_acc = cyc;
      m_instr = data;
      chk("instr", instr, m_instr);
      chk("ivalid", instr_valid, 1);
   endtask

   task automatic exec(input int wait_n, input bit h, input bit j,
                       input logic [31:0] jt, input bit b,
                       input logic [31:0] bt, input bit ack);
      logic [31:0] t;
      logic [31:0] exp_next;
      bit          redir;
      bit          fault;
      for (int i = 0; i < wait_n; i++) begin
         noise();
         ex_done = 0;
         bus.imem_valid = 1'($urandom_range(0, 1));
         bus.imem_rdata = $urandom;
         @(negedge clk);
         chk("wait_npc", next_pc, m_pc);
         @(posedge clk); #1;
         chk("wait_ivalid", instr_valid, 1);
         chk("wait_instr", instr, m_instr);
      end
      clear_ctl();
      bus.imem_valid = 0;
      ex_done = 1; halt_req = h; jmp = j; jmp_target = jt;
      br_taken = b; br_target = bt; exc_ack = ack;
      redir = 0;
      if (h)      t = m_pc;
      else if (j) begin t = jt; redir = 1; end
      else if (b) begin t = bt; redir = 1; end
      else        t = m_pc + 32'd4;
      fault    = redir && (t % 4 != 0);
      exp_next = fault ? EXC_VEC : t;
      @(negedge clk);
      chk("next_pc", next_pc, exp_next);
      @(posedge clk); #1;
      clear_ctl();
      if (fault) begin
         m_exc = 1; m_epc = m_pc;
      end else if (ack) begin
         m_exc = 0;
      end
      m_pc = exp_next;
      chk("exc_flag", exc_flag, m_exc);
      chk("epc", epc, m_epc);
      chk("halted", halted, h);
      chk("done_ivalid", instr_valid, 0);
      chk("pc", pc, m_pc);
   endtask

   task automatic rand_instr();
      logic [31:0] jt, bt;
      jt = $urandom;
      bt = $urandom;
      if ($urandom_range(0, 3) != 0) jt[1:0] = 2'b00;
      if ($urandom_range(0, 3) != 0) bt[1:0] = 2'b00;
      fetch($urandom_range(0, 3), $urandom, 0);
      exec($urandom_range(0, 2), 0, 1'($urandom_range(0, 1)), jt,
           1'($urandom_range(0, 1)), bt, 1'($urandom_range(0, 1)));
   endtask

   initial begin
      bus.imem_valid = 0;
      bus.imem_rdata = 0;
      clear_ctl();
      do_reset();

      // Back-to-back sequential: 0, 4, 8, 12 at one fetch per 2 cycles.
      fetch(0, 32'h1111_0000, 0); exec(0, 0, 0, 0, 0, 0, 0);
      fetch(0, 32'h1111_0004, 1); exec(0, 0, 0, 0, 0, 0, 0);
      fetch(0, 32'h1111_0008, 1); exec(0, 0, 0, 0, 0, 0, 0);
      fetch(0, 32'h1111_000C, 1); exec(0, 0, 0, 0, 0, 0, 0);
      // pc=16: jump beats branch.
      fetch(0, 32'h2222_0010, 1);
      exec(0, 0, 1, 32'h40, 1, 32'h80, 0);
      // Branch alone.
      fetch(0, 32'h2222_0040, 0);
      exec(0, 0, 0, 0, 1, 32'h80, 0);
      fetch(0, 32'h2222_0080, 0);
      exec(0, 0, 0, 0, 1, 32'h8, 0);
      // Memory stall of 3 cycles at pc=8.
      fetch(3, 32'hCAFE_0008, 0);
      exec(2, 0, 0, 0, 1, 32'h20, 0);
      // Misaligned jump from 0x20.
      fetch(0, 32'h3333_0020, 0);
      exec(0, 0, 1, 32'h42, 0, 0, 0);
      // Second fault with ack in the same cycle keeps the flag.
      fetch(1, 32'h3333_0080, 0);
      exec(0, 0, 0, 0, 1, 32'h81, 1);
      // Wrap-around with the flag set.
      fetch(0, 32'h4444_0080, 0);
      exec(0, 0, 0, 0, 1, 32'hFFFF_FFFC, 0);
      fetch(0, 32'h4444_FFFC, 0);
      exec(1, 0, 0, 0, 0, 0, 0);
      // Plain ack clears the flag.
      fetch(0, 32'h5555_0000, 0);
      exec(0, 0, 0, 0, 0, 0, 1);
      fetch(0, 32'h5555_0004, 0);
      exec(0, 0, 0, 0, 1, 32'h24, 0);
      // Halt at 0x24; misaligned jump alongside must not fault.
      fetch(0, 32'h6666_0024, 0);
      exec(1, 1, 1, 32'h43, 0, 0, 0);
      for (int i = 0; i < 6; i++) begin
         noise();
         bus.imem_valid = 1;
         @(negedge clk);
         chk("halt_npc", next_pc, 32'h24);
         @(posedge clk); #1;
         chk("halt_req", bus.imem_req, 0);
         chk("halt_flag", halted, 1);
         chk("halt_pc", pc, 32'h24);
      end
      bus.imem_valid = 0;
      clear_ctl();
      do_reset();
      chk("post_halt_pc", pc, 0);

      for (int n = 0; n < 40; n++) rand_instr();

      // Reset while executing discards the instruction.
      fetch(1, 32'hDEAD_BEEF, 0);
      do_reset();
      chk("abort_pc", pc, 0);
      for (int n = 0; n < 20; n++) rand_instr();

      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Fetch/execute sequencer that owns the mini-MIPS program counter register's next-value input. It issues instruction-memory fetches at the current PC, holds the PC during memory and execute stalls, and applies the redirect when execute completes: sequential, branch, jump, halt, or misalignment exception. It sits between the PC register, the instruction memory port and the decode/execute stage. The PC register loads unconditionally every clock, so this block is the only source of PC stalls.

## Interface
Parameters:
- EXC_VECTOR, 32'h0000_0080, PC loaded on a misaligned redirect target.
- PC_STEP, 4, sequential increment.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  reset, asynchronous, active-high.
- pc  in  32  current PC from the PC register.
- next_pc  out  32  combinational next value to the PC register.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address; always equals pc.
- imem_rdata  in  32  fetched instruction.
- imem_valid  in  1  imem_rdata valid this cycle.
- instr  out  32  registered instruction to decode.
- instr_valid  out  1  high throughout EXEC.
- ex_done  in  1  execute finished with the current instruction.
- br_taken  in  1  branch taken (sampled with ex_done).
- br_target  in  32  branch target.
- jmp  in  1  jump or jr (sampled with ex_done).
- jmp_target  in  32  jump target.
- halt_req  in  1  halt instruction (sampled with ex_done).
- exc_ack  in  1  clears exc_flag.
- exc_flag  out  1  sticky misaligned-target exception flag.
- epc  out  32  PC of the instruction whose redirect faulted.
- halted  out  1  high in HALT.

## Operation
- FSM states: START, FETCH, EXEC, HALT.
- START: no request. Next state FETCH.
- FETCH: imem_req=1. On imem_valid, register instr<=imem_rdata and go to EXEC. Otherwise stay in FETCH.
- EXEC: instr_valid=1. Stay until ex_done, then go to FETCH, or to HALT if halt_req.
- HALT: absorbing state; only reset exits it.
- next_pc = pc in every cycle except EXEC with ex_done. In that cycle, priority is:
  - halt_req: next_pc = pc.
  - jmp: next_pc = jmp_target.
  - br_taken: next_pc = br_target.
  - otherwise: next_pc = pc + PC_STEP.
- Misalignment: if the selected jmp or br target has bits [1:0] != 0, next_pc = EXC_VECTOR, epc <= pc, exc_flag <= 1.
- Sequential addition wraps modulo 2^32. 32'hFFFF_FFFC advances to 0, with no exception.
- imem_valid outside FETCH is ignored. ex_done, br_taken, jmp and halt_req outside EXEC are ignored.
- exc_ack clears exc_flag. If exc_ack and a new exception occur in the same cycle, the set wins.

## Timing
- Reset values: state START, imem_req 0, instr 0, instr_valid 0, exc_flag 0, epc 0, halted 0. next_pc follows pc, which is 0 under reset.
- Reset mid-fetch or mid-execute aborts immediately. The in-flight instruction is discarded.
- First imem_req asserts 1 cycle after reset deassertion.
- Minimum 2 cycles per instruction: FETCH with same-cycle imem_valid, then EXEC with same-cycle ex_done.
- The PC register captures next_pc on the same edge the FSM leaves EXEC. The following FETCH therefore presents the new pc on imem_addr.
- Memory wait of N cycles adds N cycles in FETCH. pc is held constant throughout.

## Structure
- Shared package mips_pkg holds:
  - the state enum;
  - PC_STEP;
  - default EXC_VECTOR;
  - the word-alignment mask constant.
- Sub-module pc_target_mux: combinational priority select plus alignment check. Outputs the selected target and a fault bit.
- FSM, instr/epc/exc_flag registers and the halted decode stay in pc_sequencer.

## Test plan
- Reset release, imem_valid tied 1, ex_done tied 1, no redirects:
  - required fetch addresses: 0, 4, 8, 12.
  - required spacing: one fetch every 2 cycles.
  - required first imem_req: cycle 1 after reset release.
- Memory stall: imem_valid low 3 cycles at pc=8:
  - pc held at 8 for all 4 FETCH cycles.
  - instr equals imem_rdata of the valid cycle.
- Redirects:
  - at pc=16, ex_done with jmp=1 to 32'h40 and br_taken=1 to 32'h80: next fetch at 32'h40.
  - branch alone to 32'h80: next fetch at 32'h80.
- Misaligned jmp_target 32'h42 at pc=32'h20:
  - next fetch at 32'h80; epc=32'h20; exc_flag=1.
  - exc_ack in the same cycle as a second fault leaves exc_flag=1.
- halt_req with ex_done at pc=32'h24:
  - halted=1; imem_req=0 forever; pc stays 32'h24.
  - reset returns to START and pc=0.
- Wrap-around: sequential step at pc=32'hFFFF_FFFC gives next fetch at 0 with exc_flag unchanged.
